if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/if_perf_cnt.sv | 39 +++
 rtl/if_stage.sv | 167 ++++++++++++++++
 tb/tb_if_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg -- definitions shared by the instruction-fetch slice.
//   RESET_PC_DEF  : default PC fetched first after reset
//   INST_NOP_DEF  : default value shown on inst_out while no instruction is held
//   fetch_state_t : fetch FSM state encoding
//   pc_misaligned : true when a PC is not word aligned
// ----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;
   localparam logic [31:0] INST_NOP_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_REQ  = 2'd1,
      FS_FULL = 2'd2,
      FS_ERR  = 2'd3
   } fetch_state_t;

   function automatic logic pc_misaligned(input logic [31:0] pc);
      return (pc[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/if_perf_cnt.sv
// ----------------------------------------------------------------------------
// if_perf_cnt -- fetch performance counters (built only with IF_PERF_CNT_EN).
//   clk, rst   : clock, asynchronous active-high reset
//   fetch_inc  : one accepted instruction-memory response this cycle
//   stall_inc  : one request cycle spent waiting for the memory
//   fetch_cnt  : accepted responses, wraps at 2^32
//   stall_cnt  : wait cycles, wraps at 2^32
// ----------------------------------------------------------------------------
`ifdef IF_PERF_CNT_EN
module if_perf_cnt
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_inc,
   input  logic        stall_inc,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   logic [31:0] fetch_cnt_r;
   logic [31:0] stall_cnt_r;

   // counter registers, free-running wrap on overflow
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_r <= 32'd0;
         stall_cnt_r <= 32'd0;
      end else begin
         if (fetch_inc) fetch_cnt_r <= fetch_cnt_r + 32'd1;
         if (stall_inc) stall_cnt_r <= stall_cnt_r + 32'd1;
      end
   end

   assign fetch_cnt = fetch_cnt_r;
   assign stall_cnt = stall_cnt_r;

endmodule
`endif

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- single-entry instruction fetch stage.
//   Optional feature macro: IF_PERF_CNT_EN (fetch/stall counters; tied to 0
//   when undefined).
//   clk, rst                 : clock, asynchronous active-high reset
//   pc_in                    : current PC from the PC register
//   pc_ena, npc_out          : PC register write-enable and next PC
//   redirect, redirect_pc    : one-cycle taken branch/jump target
//   imem_req, imem_addr      : instruction-memory request
//   imem_ack, imem_rdata     : instruction-memory response
//   inst_valid/ready/out/pc  : valid/ready handshake towards decode
//   fetch_err                : sticky misaligned-PC flag
//   fetch_cnt, stall_cnt     : performance counters
// ----------------------------------------------------------------------------
module if_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] INST_NOP = INST_NOP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   output logic        pc_ena,
   output logic [31:0] npc_out,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic        fetch_err,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
);

   fetch_state_t state_r, state_s;
   logic         kill_r, kill_s;
   logic [31:0]  hold_addr_r;   // address of a request whose response will be dropped
   logic         inst_valid_r;
   logic [31:0]  inst_out_r;
   logic [31:0]  inst_pc_r;
   logic         fetch_err_r;
   logic         ack_ok_s;      // response accepted into the buffer
   logic [31:0]  tgt_pc_s;      // PC the next request will use

   assign ack_ok_s = (state_r == FS_REQ) && imem_ack && !kill_r && !redirect;
   assign tgt_pc_s = redirect ? redirect_pc : pc_in;

   // fetch state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= FS_IDLE;
         kill_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         kill_r  <= kill_s;
      end
   end

   // next-state logic; every entry into REQ re-checks the alignment of the
   // PC that request will use
   always_comb begin
      state_s = state_r;
      kill_s  = kill_r;
      case (state_r)
         FS_IDLE: begin
            state_s = pc_misaligned(tgt_pc_s) ? FS_ERR : FS_REQ;
         end
         FS_REQ: begin
            if (imem_ack) begin
               kill_s = 1'b0;
               if (redirect || kill_r) begin
                  state_s = pc_misaligned(tgt_pc_s) ? FS_ERR : FS_REQ;
               end else begin
                  state_s = FS_FULL;
               end
            end else if (redirect) begin
               // outstanding request now fetches a stale PC
               kill_s  = 1'b1;
               state_s = FS_REQ;
            end else begin
               kill_s  = kill_r;
               state_s = FS_REQ;
            end
         end
         FS_FULL: begin
            if (redirect || inst_ready) begin
               state_s = pc_misaligned(tgt_pc_s) ? FS_ERR : FS_REQ;
            end else begin
               state_s = FS_FULL;
            end
         end
         FS_ERR: begin
            state_s = FS_ERR;
         end
         default: begin
            state_s = FS_ERR;
            kill_s  = 1'b0;
         end
      endcase
   end

   // request and PC-update outputs; a killed request keeps its original
   // address on the bus until the memory answers
   always_comb begin
      imem_req  = (state_r == FS_REQ);
      imem_addr = kill_r ? hold_addr_r : pc_in;
      pc_ena    = !rst && (state_r != FS_ERR) && (redirect || ack_ok_s);
      if (redirect) begin
         npc_out = redirect_pc;
      end else begin
         npc_out = pc_in + 32'd4;
      end
   end

   // instruction buffer, kill address and sticky error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_valid_r <= 1'b0;
         inst_out_r   <= INST_NOP;
         inst_pc_r    <= RESET_PC;
         fetch_err_r  <= 1'b0;
         hold_addr_r  <= RESET_PC;
      end else begin
         if (ack_ok_s) begin
            inst_valid_r <= 1'b1;
            inst_out_r   <= imem_rdata;
            inst_pc_r    <= imem_addr;
         end else if ((state_r == FS_FULL) && (inst_ready || redirect)) begin
            inst_valid_r <= 1'b0;
            inst_out_r   <= INST_NOP;
         end
         if ((state_r == FS_REQ) && redirect && !imem_ack && !kill_r) begin
            hold_addr_r <= pc_in;
         end
         fetch_err_r <= fetch_err_r | (state_s == FS_ERR);
      end
   end

   assign inst_valid = inst_valid_r;
   assign inst_out   = inst_out_r;
   assign inst_pc    = inst_pc_r;
   assign fetch_err  = fetch_err_r;

`ifdef IF_PERF_CNT_EN
   logic stall_inc_s;
   assign stall_inc_s = (state_r == FS_REQ) && !imem_ack;

   if_perf_cnt u_perf_cnt (
      .clk       (clk),
      .rst       (rst),
      .fetch_inc (ack_ok_s),
      .stall_inc (stall_inc_s),
      .fetch_cnt (fetch_cnt),
      .stall_cnt (stall_cnt)
   );
`else
   assign fetch_cnt = 32'd0;
   assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage. A small PC register and
// instruction memory are modelled here; expected {instruction, pc} pairs are
// queued when the memory answers and compared when decode accepts them.
// ----------------------------------------------------------------------------
module tb_if_stage;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_ena;
   logic [31:0] npc_out;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        fetch_err;
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;

   logic [31:0] pc_q;
   logic        force_en;
   logic [31:0] force_pc;
   int          ena_cnt;
   int          total = 0;
   int          bad   = 0;
   int          exp_fetch;
   int          exp_stall;
   logic [63:0] exp_q[$];

   if_stage dut (
      .clk         (clk),
      .rst         (rst),
      .pc_in       (pc_in),
      .pc_ena      (pc_ena),
      .npc_out     (npc_out),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_out    (inst_out),
      .inst_pc     (inst_pc),
      .fetch_err   (fetch_err),
      .fetch_cnt   (fetch_cnt),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   // PC register model
   always @(posedge clk or posedge rst) begin
      if (rst) pc_q <= RESET_PC_DEF;
      else if (pc_ena) pc_q <= npc_out;
   end

   // count pc_ena pulses seen by the PC register
   always @(posedge clk) begin
      if (!rst && pc_ena) ena_cnt <= ena_cnt + 1;
   end

   assign pc_in = force_en ? force_pc : pc_q;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_idle();
      imem_ack    = 1'b0;
      imem_rdata  = $urandom;
      redirect    = 1'b0;
      redirect_pc = $urandom;
      inst_ready  = 1'b0;
   endtask

   // one request at addr answered after 'waits' wait cycles with data
   task automatic do_fetch(input int waits, input logic [31:0] data, input logic [31:0] addr);
      for (int i = 0; i < waits; i++) begin
         @(negedge clk); drive_idle(); #1;
         check_eq("wait_req", 32'(imem_req), 32'd1);
         check_eq("wait_addr", imem_addr, addr);
         check_eq("wait_ena", 32'(pc_ena), 32'd0);
         check_eq("wait_vld", 32'(inst_valid), 32'd0);
         exp_stall++;
      end
      @(negedge clk); drive_idle(); imem_ack = 1'b1; imem_rdata = data; #1;
      check_eq("ack_req", 32'(imem_req), 32'd1);
      check_eq("ack_addr", imem_addr, addr);
      check_eq("ack_ena", 32'(pc_ena), 32'd1);
      check_eq("ack_npc", npc_out, addr + 32'd4);
      exp_q.push_back({data, addr});
      exp_fetch++;
   endtask

   // decode holds ready low for 'delay' cycles, then accepts
   task automatic drain(input int delay);
      logic [63:0] e;
      for (int i = 0; i < delay; i++) begin
         @(negedge clk); drive_idle(); #1;
         check_eq("hold_vld", 32'(inst_valid), 32'd1);
         check_eq("hold_req", 32'(imem_req), 32'd0);
         check_eq("hold_ena", 32'(pc_ena), 32'd0);
      end
      @(negedge clk); drive_idle(); inst_ready = 1'b1; #1;
      check_eq("out_vld", 32'(inst_valid), 32'd1);
      check_eq("sb_level", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check_eq("inst_out", inst_out, e[63:32]);
         check_eq("inst_pc", inst_pc, e[31:0]);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int e0;
      rst = 1'b1; force_en = 1'b0; force_pc = 32'd0; ena_cnt = 0;
      exp_fetch = 0; exp_stall = 0;
      drive_idle();
      @(negedge clk); @(negedge clk); #1;
      check_eq("rst_req", 32'(imem_req), 32'd0);
      check_eq("rst_ena", 32'(pc_ena), 32'd0);
      check_eq("rst_vld", 32'(inst_valid), 32'd0);
      check_eq("rst_inst", inst_out, 32'h0000_0000);
      check_eq("rst_ipc", inst_pc, 32'h0040_0000);
      check_eq("rst_err", 32'(fetch_err), 32'd0);
      check_eq("rst_fcnt", fetch_cnt, 32'd0);
      check_eq("rst_scnt", stall_cnt, 32'd0);
      rst = 1'b0;

      // first fetch, two wait cycles
      do_fetch(2, 32'h3C01_0040, 32'h0040_0000);
      drain(0);
      check_eq("one_ena", 32'(ena_cnt), 32'd1);

      // zero-wait ack, decode stalls three cycles
      e0 = ena_cnt;
      do_fetch(0, 32'h2421_0001, 32'h0040_0004);
      drain(3);
      check_eq("zw_ena", 32'(ena_cnt - e0), 32'd1);

      // redirect before ack: kill the outstanding response
      @(negedge clk); drive_idle(); redirect = 1'b1; redirect_pc = 32'h0040_0100; #1;
      check_eq("rd_ena", 32'(pc_ena), 32'd1);
      check_eq("rd_npc", npc_out, 32'h0040_0100);
      exp_stall++;
      @(negedge clk); drive_idle(); #1;
      check_eq("kill_req", 32'(imem_req), 32'd1);
      check_eq("kill_addr", imem_addr, 32'h0040_0008);
      check_eq("kill_ena0", 32'(pc_ena), 32'd0);
      exp_stall++;
      @(negedge clk); drive_idle(); imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
      check_eq("drop_ena", 32'(pc_ena), 32'd0);
      do_fetch(1, 32'h8C22_0000, 32'h0040_0100);
      drain(0);

      // redirect coincident with ack: drop it, no kill
      @(negedge clk); drive_idle(); imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      redirect = 1'b1; redirect_pc = 32'h0040_0200; #1;
      check_eq("co_ena", 32'(pc_ena), 32'd1);
      check_eq("co_npc", npc_out, 32'h0040_0200);
      do_fetch(0, 32'h0000_0020, 32'h0040_0200);
      drain(0);

      // redirect while an instruction is buffered
      do_fetch(0, 32'h1111_2222, 32'h0040_0204);
      @(negedge clk); drive_idle(); redirect = 1'b1; redirect_pc = 32'h0040_0300; #1;
      check_eq("fr_vld", 32'(inst_valid), 32'd1);
      check_eq("fr_ena", 32'(pc_ena), 32'd1);
      check_eq("fr_npc", npc_out, 32'h0040_0300);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      do_fetch(1, 32'h3333_4444, 32'h0040_0300);
      drain(0);
`ifdef IF_PERF_CNT_EN
      check_eq("fcnt_mix", fetch_cnt, 32'(exp_fetch));
      check_eq("scnt_mix", stall_cnt, 32'(exp_stall));
`else
      check_eq("fcnt_off", fetch_cnt, 32'd0);
      check_eq("scnt_off", stall_cnt, 32'd0);
`endif

      // reset in the middle of a request; stray ack afterwards ignored
      @(negedge clk); drive_idle(); #1;
      check_eq("mr_req", 32'(imem_req), 32'd1);
      rst = 1'b1; #1;
      check_eq("mr_req0", 32'(imem_req), 32'd0);
      check_eq("mr_vld0", 32'(inst_valid), 32'd0);
      check_eq("mr_fcnt", fetch_cnt, 32'd0);
      @(negedge clk); drive_idle(); imem_ack = 1'b1; #1;
      check_eq("mr_ack_req", 32'(imem_req), 32'd0);
      rst = 1'b0; #1;
      check_eq("mr_ack_ena", 32'(pc_ena), 32'd0);

      // four fetches, one wait cycle each
      for (int k = 0; k < 4; k++) begin
         do_fetch(1, 32'hA000_0000 + 32'(k), 32'h0040_0000 + 32'(4 * k));
         drain(0);
      end
`ifdef IF_PERF_CNT_EN
      check_eq("fcnt4", fetch_cnt, 32'd4);
      check_eq("scnt4", stall_cnt, 32'd4);
`else
      check_eq("fcnt4_off", fetch_cnt, 32'd0);
      check_eq("scnt4_off", stall_cnt, 32'd0);
`endif

      // misaligned PC at IDLE: error until reset, redirect ignored
      @(negedge clk); drive_idle(); rst = 1'b1; force_en = 1'b1; force_pc = 32'h0040_0002;
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); drive_idle();
         if (i == 2) begin
            redirect = 1'b1; redirect_pc = 32'h0040_0400;
         end
         #1;
         check_eq("err_flag", 32'(fetch_err), 32'd1);
         check_eq("err_req", 32'(imem_req), 32'd0);
         check_eq("err_ena", 32'(pc_ena), 32'd0);
      end
      rst = 1'b1; #1;
      check_eq("err_clr", 32'(fetch_err), 32'd0);
      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
